// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered multicycle results.
// Latency: pipeline writes pass through combinationally; FIFO results write no earlier than the cycle after push.
// Backpressure: mc_ready drops when the FIFO is full; a starved FIFO forces a one-cycle pipe_stall.
module wb_port_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wb_we,
    input  logic [4:0]                        wb_wa,
    input  logic [31:0]                       wb_wd,
    input  logic                              mc_valid,
    output logic                              mc_ready,
    input  logic [4:0]                        mc_wa,
    input  logic [31:0]                       mc_wd,
    output logic                              rf_we,
    output logic [4:0]                        rf_wa,
    output logic [31:0]                       rf_wd,
    output logic                              pipe_stall,
    input  logic [4:0]                        chk_addr,
    output logic                              busy_hit,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {ST_NORMAL, ST_FORCE} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [4:0]     q_wa [FIFO_DEPTH];
    logic [31:0]    q_wd [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;

    logic           fifo_empty, mc_hs, push, pop, pw;
    logic           grant_we, stall, hit;
    logic [4:0]     grant_wa;
    logic [31:0]    grant_wd;
    logic [PW-1:0]  offs;

    assign fifo_empty = (count == '0);
    assign mc_ready   = (count != CW'(FIFO_DEPTH));
    assign mc_hs      = mc_valid && mc_ready;
    // x0 results complete the handshake but are never stored
    assign push       = mc_hs && (mc_wa != 5'd0);
    assign pw         = wb_we && (wb_wa != 5'd0);

    always_comb begin
        state_d  = ST_NORMAL;
        starve_d = '0;
        pop      = 1'b0;
        grant_we = 1'b0;
        grant_wa = 5'd0;
        grant_wd = 32'd0;
        stall    = 1'b0;
        case (state_q)
            ST_FORCE: begin
                stall = 1'b1;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    grant_we = 1'b1;
                    grant_wa = q_wa[rd_ptr];
                    grant_wd = q_wd[rd_ptr];
                end
            end
            default: begin
                if (pw) begin
                    grant_we = 1'b1;
                    grant_wa = wb_wa;
                    grant_wd = wb_wd;
                    if (!fifo_empty) begin
                        if (starve_q != SW'(STARVE_LIMIT))
                            starve_d = starve_q + SW'(1);
                        else
                            starve_d = starve_q;
                    end
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    grant_we = 1'b1;
                    grant_wa = q_wa[rd_ptr];
                    grant_wd = q_wd[rd_ptr];
                end
                if (starve_d == SW'(STARVE_LIMIT))
                    state_d = ST_FORCE;
            end
        endcase
    end

    // Occupied slots are the count entries starting at rd_ptr; a popping head still hits
    always_comb begin
        hit  = 1'b0;
        offs = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            offs = PW'(i) - rd_ptr;
            if ((CW'(offs) < count) && (q_wa[i] == chk_addr))
                hit = 1'b1;
        end
        if (mc_hs && (mc_wa == chk_addr))
            hit = 1'b1;
    end

    assign rf_we      = rst_n && grant_we;
    assign rf_wa      = rf_we ? grant_wa : 5'd0;
    assign rf_wd      = rf_we ? grant_wd : 32'd0;
    assign pipe_stall = rst_n && stall;
    assign busy_hit   = rst_n && (chk_addr != 5'd0) && hit;
    assign fifo_count = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_NORMAL;
            starve_q <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_wa[wr_ptr] <= mc_wa;
            q_wd[wr_ptr] <= mc_wd;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: queue-based reference model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_we, mc_valid, mc_ready, rf_we, pipe_stall, busy_hit;
    logic [4:0]  wb_wa, mc_wa, rf_wa, chk_addr;
    logic [31:0] wb_wd, mc_wd, rf_wd;
    logic [1:0]  fifo_count;

    wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_wa(mc_wa), .mc_wd(mc_wd),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .pipe_stall(pipe_stall), .chk_addr(chk_addr), .busy_hit(busy_hit),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a queue of {wa, wd} entries, a starvation count and a force flag
    logic [36:0] mq[$];
    int          m_starve = 0;
    bit          m_force  = 1'b0;
    bit          s_pop, s_store, s_force;
    int          s_starve;
    logic [36:0] s_entry;

    initial begin
        s_pop = 0; s_store = 0; s_force = 0; s_starve = 0; s_entry = '0;
        forever begin
            @(negedge clk);
            begin : cmp
                bit          pw, empty, ready, hs, e_we, e_stall, e_busy;
                logic [4:0]  e_wa;
                logic [31:0] e_wd;
                logic [36:0] head, dummy;
                int          nst;
                e_we = 0; e_wa = 0; e_wd = 0; e_stall = 0; e_busy = 0;
                s_pop = 0; s_store = 0; s_force = 0; s_starve = 0;
                if (!rst_n) begin
                    mq.delete();
                    m_starve = 0;
                    m_force  = 0;
                    ready    = 1;
                end else begin
                    pw    = wb_we && (wb_wa != 0);
                    empty = (mq.size() == 0);
                    ready = (mq.size() != DEPTH);
                    hs    = mc_valid && ready;
                    head  = empty ? 37'd0 : mq[0];
                    if (m_force) begin
                        e_stall = 1;
                        if (!empty) begin
                            e_we = 1; e_wa = head[36:32]; e_wd = head[31:0]; s_pop = 1;
                        end
                        nst = 0;
                    end else begin
                        if (pw) begin
                            e_we = 1; e_wa = wb_wa; e_wd = wb_wd;
                        end else if (!empty) begin
                            e_we = 1; e_wa = head[36:32]; e_wd = head[31:0]; s_pop = 1;
                        end
                        if (empty || !pw) nst = 0;
                        else nst = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
                        s_force = (nst == LIMIT);
                    end
                    s_starve = nst;
                    s_store  = hs && (mc_wa != 0);
                    s_entry  = {mc_wa, mc_wd};
                    if (chk_addr != 0) begin
                        foreach (mq[i]) if (mq[i][36:32] == chk_addr) e_busy = 1;
                        if (hs && mc_wa == chk_addr) e_busy = 1;
                    end
                end
                check("cyc rf_we", rf_we, e_we);
                check("cyc rf_wa", rf_wa, e_wa);
                check("cyc rf_wd", rf_wd, e_wd);
                check("cyc pipe_stall", pipe_stall, e_stall);
                check("cyc busy_hit", busy_hit, e_busy);
                check("cyc fifo_count", fifo_count, mq.size());
                check("cyc mc_ready", mc_ready, ready);
                dummy = '0;
            end
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_starve = 0;
                m_force  = 0;
            end else begin
                if (s_pop) mq.delete(0);
                if (s_store) mq.push_back(s_entry);
                m_starve = s_starve;
                m_force  = s_force;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        wb_we = 0; wb_wa = 0; wb_wd = 0; mc_valid = 0; mc_wa = 0; mc_wd = 0; chk_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst rf_we", rf_we, 0);
        check("rst rf_wa", rf_wa, 0);
        check("rst rf_wd", rf_wd, 0);
        check("rst stall", pipe_stall, 0);
        check("rst busy", busy_hit, 0);
        check("rst count", fifo_count, 0);
        check("rst ready", mc_ready, 1);
        rst_n = 1;

        // simple drain
        tick(); mc_valid = 1; mc_wa = 5; mc_wd = 32'hDEADBEEF;
        #3 check("drain no bypass", rf_we, 0);
        tick(); mc_valid = 0;
        #3 check("drain we", rf_we, 1);
        check("drain wa", rf_wa, 5);
        check("drain wd", rf_wd, 32'hDEADBEEF);
        tick();
        #3 check("drain count", fifo_count, 0);
        check("idle wa", rf_wa, 0);
        check("idle wd", rf_wd, 0);

        // pipeline priority and forced drain
        tick(); wb_we = 1; wb_wa = 3; wb_wd = 32'h11; mc_valid = 1; mc_wa = 6; mc_wd = 32'h66;
        tick(); mc_valid = 0;
        for (int i = 0; i < 4; i++) begin
            #3 check("prio pipe wa", rf_wa, 3);
            check("prio no stall", pipe_stall, 0);
            tick();
        end
        #3 check("force stall", pipe_stall, 1);
        check("force wa", rf_wa, 6);
        check("force wd", rf_wd, 32'h66);
        tick();
        #3 check("resume stall", pipe_stall, 0);
        check("resume wa", rf_wa, 3);
        check("resume count", fifo_count, 0);

        // x0 handling
        tick(); wb_wa = 0; wb_wd = 32'h99; mc_valid = 1; mc_wa = 7; mc_wd = 32'h22;
        tick(); mc_valid = 0;
        #3 check("x0 fifo we", rf_we, 1);
        check("x0 fifo wa", rf_wa, 7);
        check("x0 fifo wd", rf_wd, 32'h22);
        tick(); mc_valid = 1; mc_wa = 0; mc_wd = 32'h55;
        #3 check("x0 push ready", mc_ready, 1);
        check("x0 pipe no we", rf_we, 0);
        tick(); mc_valid = 0;
        #3 check("x0 push not stored", fifo_count, 0);

        // full FIFO and same-cycle pop/push
        tick(); wb_wa = 3; wb_wd = 32'h33; mc_valid = 1; mc_wa = 12; mc_wd = 32'hC;
        tick(); mc_wa = 13; mc_wd = 32'hD;
        tick(); wb_we = 0; mc_wa = 14; mc_wd = 32'hE;
        #3 check("full ready", mc_ready, 0);
        check("full count", fifo_count, 2);
        check("full pop wa", rf_wa, 12);
        tick();
        #3 check("refill ready", mc_ready, 1);
        check("refill count", fifo_count, 1);
        check("refill pop wa", rf_wa, 13);
        tick(); mc_valid = 0;
        #3 check("accepted wa", rf_wa, 14);
        check("accepted wd", rf_wd, 32'hE);
        tick();
        #3 check("full end count", fifo_count, 0);

        // pending-write hits
        tick(); wb_we = 1; wb_wa = 3; mc_valid = 1; mc_wa = 9; mc_wd = 32'h9; chk_addr = 9;
        #3 check("busy push", busy_hit, 1);
        tick(); mc_valid = 0;
        #1 check("busy held", busy_hit, 1);
        chk_addr = 10;
        #1 check("busy other", busy_hit, 0);
        chk_addr = 0; mc_valid = 1; mc_wa = 0;
        #1 check("busy x0", busy_hit, 0);
        tick(); wb_we = 0; mc_valid = 0; chk_addr = 9;
        #3 check("busy popping", busy_hit, 1);
        check("busy pop wa", rf_wa, 9);
        tick();
        #3 check("busy cleared", busy_hit, 0);

        // asynchronous reset in the middle of a drain
        tick(); wb_we = 1; wb_wa = 3; mc_valid = 1; mc_wa = 20; mc_wd = 32'h1;
        tick(); mc_wa = 21; mc_wd = 32'h2;
        tick(); mc_valid = 0; wb_we = 0;
        #1 check("pre-rst count", fifo_count, 2);
        check("pre-rst we", rf_we, 1);
        #1 rst_n = 0;
        #1 check("arst count", fifo_count, 0);
        check("arst we", rf_we, 0);
        check("arst stall", pipe_stall, 0);
        tick(); rst_n = 1;
        #3 check("post-rst ready", mc_ready, 1);
        check("post-rst count", fifo_count, 0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port.
- Shares the port between two requesters:
  - the in-order pipeline writeback (rf_wr_sel mux result and regWrite from the memory register);
  - a multicycle execution unit (mul/div), whose results arrive out of band through a small result FIFO.
- The pipeline has priority. A starvation counter forces a one-cycle pipeline stall so buffered multicycle results drain.
- Also reports per-register pending-write hits so decode can hold dependent instructions.

Parameters:
- FIFO_DEPTH, 2, number of buffered multicycle results (power of two, >=2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may be denied the port before a forced drain.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- WB_WE  input  1  pipeline write request (regWrite from memory register).
- WB_WA  input  5  pipeline destination register (ir[11:7]).
- WB_WD  input  32  pipeline write data (reg-file mux output).
- MC_VALID  input  1  multicycle result valid.
- MC_READY  output  1  FIFO can accept a result.
- MC_WA  input  5  multicycle destination register.
- MC_WD  input  32  multicycle result data.
- RF_WE  output  1  register-file write enable.
- RF_WA  output  5  register-file write address.
- RF_WD  output  32  register-file write data.
- PIPE_STALL  output  1  pipeline must hold its memory/writeback register this cycle.
- CHK_ADDR  input  5  decode source register to check.
- BUSY_HIT  output  1  CHK_ADDR has a pending multicycle write.
- FIFO_COUNT  output  $clog2(FIFO_DEPTH+1)  occupied FIFO entries.

Behaviour:
- Reset (RST_N low, async):
  - FIFO emptied and in-flight entries discarded.
  - State = NORMAL; starve_cnt = 0.
  - Outputs: RF_WE=0, RF_WA=0, RF_WD=0, PIPE_STALL=0, BUSY_HIT=0, FIFO_COUNT=0, MC_READY=1.
  - No push occurs while RST_N is low.
- FIFO push and ordering:
  - MC_READY = (FIFO_COUNT != FIFO_DEPTH), combinational. A pop in the same cycle does not raise READY.
  - Push on the rising edge when MC_VALID && MC_READY.
  - A result with MC_WA==0 is handshaken but not stored.
  - FIFO order is preserved.
  - Simultaneous push and pop leaves the count unchanged.
- No bypass: a result pushed at edge N is written no earlier than the cycle after edge N.
- Grant in state NORMAL (combinational; pop and counter updates take effect at the edge):
  - pw = WB_WE && WB_WA!=0.
  - If pw: port = pipeline. If the FIFO is non-empty, starve_cnt++ (saturating).
  - Else if FIFO non-empty: port = FIFO head, pop, starve_cnt=0.
  - Else: RF_WE=0.
  - Whenever the FIFO is empty, starve_cnt=0.
  - When starve_cnt == STARVE_LIMIT at the edge, next state = FORCE.
- State FORCE (exactly one cycle):
  - PIPE_STALL=1; port = FIFO head, pop.
  - The pipeline request is ignored this cycle. The pipeline holds its inputs, so the write is retried next cycle, not lost.
  - Next state NORMAL, starve_cnt=0.
- Writes to x0: WB_WE with WB_WA==0 never asserts RF_WE and never counts as using the port.
- Idle port: when RF_WE=0, RF_WA and RF_WD are driven 0.
- BUSY_HIT:
  - Asserts if CHK_ADDR!=0 and it matches any valid FIFO entry, or matches MC_WA of a push occurring this cycle.
  - An entry being popped this cycle still counts as a hit.
- Ordering between pipeline and multicycle writes to the same register is not enforced here. Decode uses BUSY_HIT to stall, preventing WAW.
- No error outputs. Overflow is impossible by handshake. starve_cnt saturates at STARVE_LIMIT.

Test Plan:
- Reset checks:
  - Assert RST_N low mid-drain with FIFO_COUNT=2 → FIFO_COUNT=0, RF_WE=0, PIPE_STALL=0 immediately (async).
  - After release, MC_READY=1.
- Simple drain: WB_WE=0, push {MC_WA=5, MC_WD=0xDEADBEEF} at edge N → cycle after N: RF_WE=1, RF_WA=5, RF_WD=0xDEADBEEF; next cycle FIFO_COUNT=0.
- Pipeline priority: WB_WE=1 WB_WA=3 WB_WD=0x11 every cycle while FIFO holds 1 entry → RF_WA=3 for 4 cycles, then exactly one cycle with PIPE_STALL=1 and the FIFO entry written, then RF_WA=3 resumes.
- x0 handling:
  - WB_WE=1, WB_WA=0 with FIFO entry {7, 0x22} → RF_WA=7, RF_WD=0x22, no starve increment.
  - Push with MC_WA=0 → FIFO_COUNT unchanged.
- Full and same-cycle traffic: fill FIFO (2 entries, WB busy) → MC_READY=0. Then pop and offer push in the same cycle → push refused; accepted the following cycle.
- BUSY_HIT: FIFO holds {9, x} and CHK_ADDR=9 → BUSY_HIT=1; CHK_ADDR=10 → 0; CHK_ADDR=0 with an x0 push → 0; after entry 9 is written (next cycle) → BUSY_HIT=0.
